riscv_reg_dump_ctrl: RTL

RISCV_REG_DUMP_CTRL -- requirements
Module: riscv_reg_dump_ctrl

---
 rtl/riscv_reg_dump_ctrl_pkg.sv | 16 +
 rtl/riscv_reg_dump_ctrl_if.sv | 30 +++
 rtl/riscv_reg_dump_ctrl_cycle_counter.sv | 25 ++
 rtl/riscv_reg_dump_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/riscv_reg_dump_ctrl_pkg.sv
// Shared types and widths for the register-dump controller.
package riscv_dbg_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DISP_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        SETTLE,
        EMIT,
        DONE
    } dump_state_t;

endpackage

// File: rtl/riscv_reg_dump_ctrl_if.sv
// Bus bundle between the dump controller, the pipeline core and the dump consumer.
interface riscv_reg_dump_ctrl_if;
    import riscv_dbg_pkg::*;

    logic                 go;
    logic [7:0]           run_cycles;
    logic                 cpu_reset;
    logic                 cpu_start;
    logic [REG_IDX_W-1:0] cpu_sw;
    logic [DISP_W-1:0]    cpu_out;
    logic                 dump_valid;
    logic                 dump_ready;
    logic [REG_IDX_W-1:0] dump_idx;
    logic [DISP_W-1:0]    dump_data;
    logic                 busy;
    logic                 done;

    // Controller side
    modport slave (
        input  go, run_cycles, cpu_out, dump_ready,
        output cpu_reset, cpu_start, cpu_sw, dump_valid, dump_idx, dump_data, busy, done
    );

    // Stimulus / core / consumer side
    modport master (
        output go, run_cycles, cpu_out, dump_ready,
        input  cpu_reset, cpu_start, cpu_sw, dump_valid, dump_idx, dump_data, busy, done
    );

endinterface

// File: rtl/riscv_reg_dump_ctrl_cycle_counter.sv
// Loadable 8-bit down-counter that parks at zero; times RUN and SETTLE.
module cycle_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count;

    // Load wins over the free-running decrement; the count holds once it reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/riscv_reg_dump_ctrl.sv
// Resets and runs the pipeline core, then scans its register display port word by word.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for go
// RST    | one-cycle cpu_reset pulse
// RUN    | cpu_start held for the latched run_cycles
// SETTLE | cpu_sw driven with the index, waiting for cpu_out to settle
// EMIT   | captured word offered on dump_valid until dump_ready
// DONE   | one-cycle done pulse
module riscv_reg_dump_ctrl
    import riscv_dbg_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset,
    riscv_reg_dump_ctrl_if.slave bus
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX    = REG_IDX_W'(NUM_REGS - 1);
    localparam logic [7:0]           SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    dump_state_t          state;
    logic [7:0]           run_q;
    logic [REG_IDX_W-1:0] idx;
    logic                 cnt_load;
    logic [7:0]           cnt_val;
    logic                 cnt_zero;

    logic                 cpu_reset_q;
    logic                 cpu_start_q;
    logic [REG_IDX_W-1:0] cpu_sw_q;
    logic                 dump_valid_q;
    logic [REG_IDX_W-1:0] dump_idx_q;
    logic [DISP_W-1:0]    dump_data_q;
    logic                 busy_q;
    logic                 done_q;

    // Counter reloads: at the start of RUN or SETTLE, loaded with (length - 1).
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = SETTLE_LOAD;
        case (state)
            RST: begin
                cnt_load = 1'b1;
                cnt_val  = (run_q == 8'd0) ? SETTLE_LOAD : run_q - 8'd1;
            end
            RUN:     cnt_load = cnt_zero;
            EMIT:    cnt_load = bus.dump_ready && (idx != LAST_IDX);
            default: cnt_load = 1'b0;
        endcase
    end

    cycle_counter u_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            run_q        <= 8'd0;
            idx          <= '0;
            cpu_reset_q  <= 1'b0;
            cpu_start_q  <= 1'b0;
            cpu_sw_q     <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        run_q       <= bus.run_cycles;
                        cpu_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= RST;
                    end
                end
                RST: begin
                    cpu_reset_q <= 1'b0;
                    idx         <= '0;
                    if (run_q == 8'd0) begin
                        cpu_sw_q <= '0;
                        state    <= SETTLE;
                    end else begin
                        cpu_start_q <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_zero) begin
                        cpu_start_q <= 1'b0;
                        cpu_sw_q    <= '0;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    // cpu_out is only looked at on this capture edge.
                    if (cnt_zero) begin
                        dump_data_q  <= bus.cpu_out;
                        dump_idx_q   <= idx;
                        dump_valid_q <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.dump_ready) begin
                        dump_valid_q <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx      <= idx + 1'b1;
                            cpu_sw_q <= idx + 1'b1;
                            state    <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.cpu_start  = cpu_start_q;
    assign bus.cpu_sw     = cpu_sw_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_idx   = dump_idx_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
